// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default frame parameters
// used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        Idle     = 2'd0,
        StartBit = 2'd1,
        DataBits = 2'd2,
        StopBit  = 2'd3
    } uart_state_e;

    localparam int DEFAULT_DATA_WIDTH      = 8;
    localparam int DEFAULT_OVERSAMPLE_RATE = 16;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input; 2 clk_i latency.
// Reset value is a parameter so idle-high lines come out of reset inactive.
module uart_sync #(
    parameter logic RstVal = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_meta <= RstVal;
            r_sync <= RstVal;
        end else begin
            r_meta <= d_i;
            r_sync <= r_meta;
        end
    end

    assign q_o = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1-style frames sampled mid-bit at OversampleRate ticks/bit.
// dv_o/frame_err_o pulse one cycle after the stop-bit sample; no backpressure.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DataWidth      = DEFAULT_DATA_WIDTH,
    parameter int OversampleRate = DEFAULT_OVERSAMPLE_RATE
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 tick_i,
    input  logic                 rxd_i,
    output logic [DataWidth-1:0] data_o,
    output logic                 dv_o,
    output logic                 frame_err_o,
    output logic                 busy_o
);

    localparam int TW = $clog2(OversampleRate);
    localparam int BW = (DataWidth > 1) ? $clog2(DataWidth) : 1;

    localparam logic [TW-1:0] HALF_M1  = TW'(OversampleRate / 2 - 1);
    localparam logic [TW-1:0] FULL_M1  = TW'(OversampleRate - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DataWidth - 1);

    logic                 w_rxd_s;
    uart_state_e          r_state;
    uart_state_e          w_state_nxt;
    logic                 w_state_chg;
    logic                 w_full_tick;
    logic [TW-1:0]        r_tick_cnt;
    logic [BW-1:0]        r_bit_cnt;
    logic [DataWidth-1:0] r_shift;
    logic [DataWidth-1:0] r_data;
    logic                 r_dv;
    logic                 r_ferr;

    uart_sync #(
        .RstVal (1'b1)
    ) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (rxd_i),
        .q_o   (w_rxd_s)
    );

    assign w_full_tick = tick_i && (r_tick_cnt == FULL_M1);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            Idle: begin
                if (!w_rxd_s) w_state_nxt = StartBit;
            end
            StartBit: begin
                // Mid-start check: a line that has gone high again was a glitch.
                if (tick_i && (r_tick_cnt == HALF_M1))
                    w_state_nxt = w_rxd_s ? Idle : DataBits;
            end
            DataBits: begin
                if (w_full_tick && (r_bit_cnt == LAST_BIT)) w_state_nxt = StopBit;
            end
            StopBit: begin
                if (w_full_tick) w_state_nxt = Idle;
            end
            default: w_state_nxt = Idle;
        endcase
    end

    assign w_state_chg = (w_state_nxt != r_state);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= Idle;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_data     <= '0;
            r_dv       <= 1'b0;
            r_ferr     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_dv    <= 1'b0;
            r_ferr  <= 1'b0;

            if (w_state_chg) begin
                r_tick_cnt <= '0;
                r_bit_cnt  <= '0;
            end else if (tick_i && (r_state != Idle)) begin
                if ((r_state == DataBits) && (r_tick_cnt == FULL_M1)) begin
                    r_tick_cnt <= '0;
                    r_bit_cnt  <= r_bit_cnt + 1'b1;
                end else begin
                    r_tick_cnt <= r_tick_cnt + 1'b1;
                end
            end

            if ((r_state == DataBits) && w_full_tick)
                r_shift <= {w_rxd_s, r_shift[DataWidth-1:1]};

            if ((r_state == StopBit) && w_full_tick) begin
                if (w_rxd_s) begin
                    r_data <= r_shift;
                    r_dv   <= 1'b1;
                end else begin
                    r_ferr <= 1'b1;
                end
            end
        end
    end

    assign data_o      = r_data;
    assign dv_o        = r_dv;
    assign frame_err_o = r_ferr;
    assign busy_o      = (r_state != Idle);

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver: recovers serial frames from the asynchronous `rxd_i` line and presents each received word as a parallel `data_o` with a single-cycle valid strobe. It is the receive-side partner of the UART transmitter in the peripheral subsystem and shares its baud tick source. Each frame is 1 start bit, `DataWidth` data bits (LSB first), 1 stop bit, with no parity. The block samples the line at `OversampleRate` ticks per bit and takes each bit at its midpoint.

## Interface
- `DataWidth`, 8: data bits per frame.
- `OversampleRate`, 16: `tick_i` pulses per bit period; must be even and ≥ 4.
- `clk_i`  input  1  system clock; all logic on the rising edge.
- `rst_i`  input  1  reset, synchronous, active-high.
- `tick_i`  input  1  oversample strobe, one `clk_i` cycle wide, `OversampleRate` per bit period.
- `rxd_i`  input  1  asynchronous serial line; idle high.
- `data_o`  output  `DataWidth`  last successfully received word; holds until the next good frame.
- `dv_o`  output  1  one-cycle pulse; `data_o` is valid in the same cycle.
- `frame_err_o`  output  1  one-cycle pulse; the stop bit was sampled low.
- `busy_o`  output  1  high while a frame is in progress (any state other than Idle).

## Operation
- `rxd_i` passes through a 2-flop synchronizer; both flops reset to 1. All decisions use the synchronized value `rxd_s`.
- Tick counter width is `$clog2(OversampleRate)`. Bit counter width is `$clog2(DataWidth)`. Both counters change only on cycles where `tick_i` is high, except that they clear on a state change.
- **Idle**
  - On `rxd_s == 0` (tick not required): clear the tick counter and go to StartBit.
- **StartBit**
  - On each tick: increment the tick counter.
  - On the tick where the counter equals `OversampleRate/2-1`:
    - If `rxd_s == 0`: clear the counters and go to DataBits.
    - Else: treat as a glitch and return to Idle with no output pulse.
- **DataBits**
  - On the tick where the tick counter equals `OversampleRate-1`: shift `rxd_s` into the MSB of the shift register (right shift), clear the tick counter, and increment the bit counter.
  - After bit `DataWidth-1` is sampled, go to StopBit.
- **StopBit**
  - On the tick where the tick counter equals `OversampleRate-1`:
    - If `rxd_s == 1`: load `data_o` from the shift register and pulse `dv_o`.
    - Else: pulse `frame_err_o` and leave `data_o` unchanged.
  - In both cases, go to Idle.
- Returning to Idle at mid-stop-bit allows the next start edge to be detected immediately (back-to-back frames).
- A line held low (break condition) produces `frame_err_o` and then an immediate new StartBit. The receiver does not lock up.
- `dv_o` and `frame_err_o` are never high in the same cycle.

## Timing
- **Reset values:** `data_o = 0`, `dv_o = 0`, `frame_err_o = 0`, `busy_o = 0`, state = Idle, counters = 0, synchronizer = 1.
- **Reset mid-frame:** the frame is abandoned with no pulse. Reception resumes with the first falling edge after `rst_i` deasserts.
- **Synchronizer latency:** 2 `clk_i` cycles from `rxd_i` to `rxd_s`.
- **`busy_o`** rises the cycle after `rxd_s` falls in Idle.
- **Frame latency:** from the cycle StartBit is entered, `dv_o`/`frame_err_o` asserts the cycle after the stop-sample tick. That sample is tick number `OversampleRate/2 + (DataWidth+1)*OversampleRate`, which is 152 ticks for the default parameters.
- **`busy_o`** falls in the same cycle `dv_o`/`frame_err_o` asserts.
- `dv_o`/`frame_err_o` are registered outputs, high for exactly one `clk_i` cycle.
- There is no backpressure. The consumer must capture `data_o` before the next `dv_o`, and `data_o` is stable for at least one frame time.

## Structure
- The shared package `uart_pkg` holds:
  - `uart_state_e {Idle, StartBit, DataBits, StopBit}`, common to transmitter and receiver.
  - the default `DataWidth`/`OversampleRate` constants.
- Sub-module `uart_sync`: a 2-flop synchronizer with a reset-value parameter. The receiver instantiates it with reset value 1.
- The FSM uses a single sequential process plus a next-state combinational process. The shift register, counters, and output pulses are all registered.

## Test plan
- Send 0xA5 at 16x oversampling with exact bit timing. Expect one `dv_o` pulse with `data_o == 0xA5`, `frame_err_o` never high, and `busy_o` high for 152 ticks.
- Send back-to-back 0x00 then 0xFF with no idle gap. Expect two `dv_o` pulses with `data_o` 0x00 then 0xFF.
- Drive a start glitch: `rxd_i` low for 4 ticks, then high. Expect `busy_o` to return low after tick 8 with no `dv_o` or `frame_err_o`, then a following 0x3C frame received correctly.
- Send frame 0x5A with the stop bit driven low. Expect a `frame_err_o` pulse with no `dv_o`, and `data_o` still holding the previous value (0xA5).
- Assert `rst_i` for one cycle during data bit 3 of a frame. Expect all outputs 0 on the next cycle, no pulse for the aborted frame, and a subsequent 0xC3 frame received correctly.
- Shift sample timing: apply ±5 ticks of bit-period skew to 0x96 (±0.3 bit accumulated by the stop bit). Expect 0x96 received correctly.
